// File: rtl/count_mon_pkg.sv
// Shared types for the counter event monitor: event codes and the packed event record.
package count_mon_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      WRAP_UP = 2'd0,
      WRAP_DN = 2'd1,
      THRESH  = 2'd2,
      JUMP    = 2'd3
   } evt_code_t;

   typedef struct packed {
      evt_code_t              code;
      logic [DEF_WIDTH-1:0]   value;
   } evt_t;

endpackage

// File: rtl/count_event_monitor_evt_fifo.sv
// Small registered event FIFO with wrap-around pointers; head visible the cycle after push.
// A push while full is accepted only when a pop happens in the same cycle.
module evt_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q;
   logic          do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Empty FIFO presents zeros so the head fields have a defined reset value.
   assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/count_event_monitor.sv
// Classifies each counter step (wrap/threshold/jump), queues events, keeps wrap stats and drop flag.
// Event visible one cycle after the step; drained by valid/ready, dropped (sticky flag) when full.
module count_event_monitor
   import count_mon_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int DEPTH  = 4,
   parameter int STAT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  q_in,
   input  logic              updown,
   input  logic [WIDTH-1:0]  thresh,
   input  logic              thresh_we,
   input  logic              clr_stats,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [1:0]        evt_code,
   output logic [WIDTH-1:0]  evt_value,
   output logic [STAT_W-1:0] wrap_count,
   output logic              evt_drop
);

   localparam logic [WIDTH-1:0] MAX   = '1;
   localparam int               EVT_W = 2 + WIDTH;

   logic [WIDTH-1:0]  q_prev_q, thr_q;
   logic              prev_valid_q;
   logic [STAT_W-1:0] wrap_cnt_q, wrap_cnt_d;
   logic              drop_q, drop_d;

   logic              wrap_up, wrap_dn, thr_hit, jump, is_wrap, det;
   evt_code_t         det_code;
   logic [WIDTH-1:0]  q_inc, q_dec;
   logic              fifo_full, fifo_empty, fifo_pop, fifo_push, drop;
   logic [EVT_W-1:0]  fifo_din, fifo_dout;

   assign q_inc = q_prev_q + WIDTH'(1);
   assign q_dec = q_prev_q - WIDTH'(1);

   always_comb begin
      wrap_up = prev_valid_q && updown  && (q_prev_q == MAX) && (q_in == '0);
      wrap_dn = prev_valid_q && !updown && (q_prev_q == '0) && (q_in == MAX);
      thr_hit = prev_valid_q && (q_in == thr_q) && (q_prev_q != thr_q);
      jump    = prev_valid_q && (q_in != q_prev_q) && (q_in != q_inc) && (q_in != q_dec);
      is_wrap = wrap_up || wrap_dn;
      det     = is_wrap || thr_hit || jump;
      // Wrap beats threshold beats jump when several conditions coincide.
      det_code = WRAP_UP;
      if (wrap_up)      det_code = WRAP_UP;
      else if (wrap_dn) det_code = WRAP_DN;
      else if (thr_hit) det_code = THRESH;
      else if (jump)    det_code = JUMP;
   end

   assign fifo_pop  = evt_valid && evt_ready;
   assign fifo_push = det && (!fifo_full || fifo_pop);
   assign drop      = det && fifo_full && !fifo_pop;
   assign fifo_din  = {det_code, q_in};

   always_comb begin
      wrap_cnt_d = wrap_cnt_q;
      if (clr_stats)
         wrap_cnt_d = is_wrap ? STAT_W'(1) : '0;
      else if (is_wrap && (wrap_cnt_q != '1))
         wrap_cnt_d = wrap_cnt_q + STAT_W'(1);

      drop_d = drop_q;
      if (drop)           drop_d = 1'b1;
      else if (clr_stats) drop_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_prev_q     <= '0;
         prev_valid_q <= 1'b0;
         thr_q        <= MAX;
         wrap_cnt_q   <= '0;
         drop_q       <= 1'b0;
      end else begin
         q_prev_q     <= q_in;
         prev_valid_q <= 1'b1;
         if (thresh_we) thr_q <= thresh;
         wrap_cnt_q   <= wrap_cnt_d;
         drop_q       <= drop_d;
      end
   end

   evt_fifo #(.DEPTH(DEPTH), .W(EVT_W)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .din_i   (fifo_din),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign evt_valid  = !fifo_empty;
   assign evt_code   = fifo_dout[EVT_W-1 -: 2];
   assign evt_value  = fifo_dout[WIDTH-1:0];
   assign wrap_count = wrap_cnt_q;
   assign evt_drop   = drop_q;

endmodule

// File: tb/tb_count_event_monitor.sv
// Scoreboarded bench for count_event_monitor: expected events queued at stimulus, compared on drain.
module tb_count_event_monitor;
   import count_mon_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] q_in;
   logic       updown;
   logic [7:0] thresh;
   logic       thresh_we;
   logic       clr_stats;
   logic       evt_valid;
   logic       evt_ready;
   logic [1:0] evt_code;
   logic [7:0] evt_value;
   logic [7:0] wrap_count;
   logic       evt_drop;

   always #5 clk = ~clk;

   count_event_monitor #(.WIDTH(8), .DEPTH(4), .STAT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .q_in       (q_in),
      .updown     (updown),
      .thresh     (thresh),
      .thresh_we  (thresh_we),
      .clr_stats  (clr_stats),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_code   (evt_code),
      .evt_value  (evt_value),
      .wrap_count (wrap_count),
      .evt_drop   (evt_drop)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   evt_t exp_q[$];
   evt_t mon_e;

   // Reference state derived from the stimulus only.
   logic       pv_m;
   logic [7:0] prev_m, thr_m, wc_m;
   logic       drop_m;

   always @(negedge clk) begin
      if (!rst) begin
         n_checks++;
         if (evt_valid !== (exp_q.size() != 0)) begin
            n_fail++;
            $display("FAIL valid_vs_scoreboard: evt_valid=%b expected pending=%0d", evt_valid, exp_q.size());
         end
         if (evt_valid && evt_ready && exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            if ({evt_code, evt_value} !== mon_e) begin
               n_fail++;
               $display("FAIL drain_order: got code=%0d value=%h expected code=%0d value=%h",
                        evt_code, evt_value, mon_e.code, mon_e.value);
            end
         end
         n_checks++;
         if (wrap_count !== wc_m || evt_drop !== drop_m) begin
            n_fail++;
            $display("FAIL stats: wrap_count=%0d evt_drop=%b expected %0d %b", wrap_count, evt_drop, wc_m, drop_m);
         end
      end
   end

   task automatic step(input logic [7:0] qv);
      logic [1:0] code;
      logic       hit, is_wrap, pop, dropv;
      int         occ;
      q_in = qv;
      occ  = exp_q.size();
      hit = 1'b0; code = 2'd0; is_wrap = 1'b0;
      if (pv_m) begin
         if (updown && prev_m == 8'hFF && qv == 8'h00) begin hit = 1'b1; code = 2'd0; is_wrap = 1'b1; end
         else if (!updown && prev_m == 8'h00 && qv == 8'hFF) begin hit = 1'b1; code = 2'd1; is_wrap = 1'b1; end
         else if (qv == thr_m && prev_m != thr_m) begin hit = 1'b1; code = 2'd2; end
         else if (qv != prev_m && qv != 8'(prev_m + 1) && qv != 8'(prev_m - 1)) begin hit = 1'b1; code = 2'd3; end
      end
      pop   = evt_ready && (occ > 0);
      dropv = hit && (occ == 4) && !pop;
      @(posedge clk);
      if (hit && !dropv) exp_q.push_back('{code: evt_code_t'(code), value: qv});
      if (clr_stats) wc_m = is_wrap ? 8'd1 : 8'd0;
      else if (is_wrap && wc_m != 8'hFF) wc_m = wc_m + 8'd1;
      if (dropv) drop_m = 1'b1;
      else if (clr_stats) drop_m = 1'b0;
      if (thresh_we) thr_m = thresh;
      pv_m = 1'b1;
      prev_m = qv;
      #1;
      thresh_we = 1'b0;
      clr_stats = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; updown = 1'b1; evt_ready = 1'b1;
      thresh_we = 1'b0; clr_stats = 1'b0; thresh = 8'h00;
      @(posedge clk);
      @(posedge clk);
      exp_q.delete();
      pv_m = 1'b0; prev_m = 8'h00; thr_m = 8'hFF; wc_m = 8'h00; drop_m = 1'b0;
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      q_in = 8'h80;
      do_reset();
      n_checks++;
      if (evt_valid !== 1'b0 || evt_code !== 2'd0 || evt_value !== 8'h00 ||
          wrap_count !== 8'h00 || evt_drop !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: valid=%b code=%0d value=%h wrap=%0d drop=%b expected all zero",
                  evt_valid, evt_code, evt_value, wrap_count, evt_drop);
      end
   endtask

   task automatic test_no_events();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(8'(i));
         n_checks++;
         if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL unit_step_quiet: evt_valid=%b expected 0 at q=%0d", evt_valid, i);
         end
      end
      n_checks++;
      if (wrap_count !== 8'd0) begin
         n_fail++;
         $display("FAIL unit_step_wrapcnt: wrap_count=%0d expected 0", wrap_count);
      end
   endtask

   task automatic test_wrap();
      updown = 1'b1;
      thresh = 8'h10; thresh_we = 1'b1;
      step(8'hFE);
      step(8'hFF);
      step(8'h00);
      n_checks++;
      if (evt_valid !== 1'b1 || evt_code !== 2'd0 || evt_value !== 8'h00 || wrap_count !== 8'd1) begin
         n_fail++;
         $display("FAIL wrap_up: valid=%b code=%0d value=%h wrap=%0d expected 1 0 00 1",
                  evt_valid, evt_code, evt_value, wrap_count);
      end
      updown = 1'b0;
      step(8'hFF);
      n_checks++;
      if (evt_valid !== 1'b1 || evt_code !== 2'd1 || evt_value !== 8'hFF || wrap_count !== 8'd2) begin
         n_fail++;
         $display("FAIL wrap_dn: valid=%b code=%0d value=%h wrap=%0d expected 1 1 ff 2",
                  evt_valid, evt_code, evt_value, wrap_count);
      end
   endtask

   task automatic test_thresh();
      updown = 1'b1;
      step(8'h0E);
      step(8'h0F);
      step(8'h10);
      n_checks++;
      if (evt_valid !== 1'b1 || evt_code !== 2'd2 || evt_value !== 8'h10) begin
         n_fail++;
         $display("FAIL thresh_entry: valid=%b code=%0d value=%h expected 1 2 10", evt_valid, evt_code, evt_value);
      end
      for (int i = 0; i < 3; i++) begin
         step(8'h10);
         n_checks++;
         if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL thresh_dwell: evt_valid=%b expected 0 on hold %0d", evt_valid, i);
         end
      end
      step(8'h11);
      thresh = 8'h00; thresh_we = 1'b1;
      step(8'h12);
      step(8'hFF);
      step(8'h00);
      n_checks++;
      if (evt_valid !== 1'b1 || evt_code !== 2'd0 || evt_value !== 8'h00) begin
         n_fail++;
         $display("FAIL wrap_over_thresh: valid=%b code=%0d value=%h expected 1 0 00", evt_valid, evt_code, evt_value);
      end
      // Threshold write takes effect only from the following cycle.
      thresh = 8'h01; thresh_we = 1'b1;
      step(8'h01);
      n_checks++;
      if (evt_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL thresh_write_cycle: evt_valid=%b expected 0", evt_valid);
      end
      step(8'h02);
      step(8'h01);
      n_checks++;
      if (evt_valid !== 1'b1 || evt_code !== 2'd2 || evt_value !== 8'h01) begin
         n_fail++;
         $display("FAIL thresh_new_value: valid=%b code=%0d value=%h expected 1 2 01", evt_valid, evt_code, evt_value);
      end
   endtask

   task automatic test_jump();
      step(8'h05);
      step(8'h80);
      n_checks++;
      if (evt_valid !== 1'b1 || evt_code !== 2'd3 || evt_value !== 8'h80) begin
         n_fail++;
         $display("FAIL jump: valid=%b code=%0d value=%h expected 1 3 80", evt_valid, evt_code, evt_value);
      end
      do_reset();
      q_in = 8'h80;
      for (int i = 0; i < 2; i++) begin
         step(8'h80);
         n_checks++;
         if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL priming: evt_valid=%b expected 0 on cycle %0d", evt_valid, i);
         end
      end
   endtask

   task automatic test_overflow();
      logic [7:0] jv [5];
      jv = '{8'h40, 8'h60, 8'h20, 8'h50, 8'h30};
      do_reset();
      step(8'h00);
      evt_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(jv[i]);
         n_checks++;
         if (evt_valid !== 1'b1 || evt_code !== 2'd3 || evt_value !== 8'h40) begin
            n_fail++;
            $display("FAIL head_stable: code=%0d value=%h expected 3 40 after jump %0d", evt_code, evt_value, i);
         end
      end
      n_checks++;
      if (evt_drop !== 1'b1) begin
         n_fail++;
         $display("FAIL drop_set: evt_drop=%b expected 1", evt_drop);
      end
      evt_ready = 1'b1;
      step(8'h70);
      for (int i = 0; i < 5; i++) step(8'h70);
      n_checks++;
      if (evt_valid !== 1'b0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_complete: evt_valid=%b pending=%0d expected 0 0", evt_valid, exp_q.size());
      end
      clr_stats = 1'b1;
      step(8'h70);
      n_checks++;
      if (evt_drop !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_clear: evt_drop=%b expected 0", evt_drop);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      thresh = 8'h10; thresh_we = 1'b1;
      step(8'h00);
      for (int i = 0; i < 130; i++) begin
         updown = 1'b0; step(8'hFF);
         updown = 1'b1; step(8'h00);
      end
      n_checks++;
      if (wrap_count !== 8'hFF) begin
         n_fail++;
         $display("FAIL wrap_saturate: wrap_count=%0d expected 255", wrap_count);
      end
      updown = 1'b0; step(8'hFF);
      n_checks++;
      if (wrap_count !== 8'hFF) begin
         n_fail++;
         $display("FAIL wrap_hold: wrap_count=%0d expected 255", wrap_count);
      end
      updown = 1'b1; clr_stats = 1'b1;
      step(8'h00);
      n_checks++;
      if (wrap_count !== 8'd1) begin
         n_fail++;
         $display("FAIL clr_with_wrap: wrap_count=%0d expected 1", wrap_count);
      end
   endtask

   task automatic test_reset_flush();
      evt_ready = 1'b0;
      step(8'h40);
      step(8'h90);
      step(8'h20);
      n_checks++;
      if (evt_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_setup: evt_valid=%b expected 1", evt_valid);
      end
      rst = 1'b1;
      @(posedge clk);
      exp_q.delete();
      pv_m = 1'b0; prev_m = 8'h00; thr_m = 8'hFF; wc_m = 8'h00; drop_m = 1'b0;
      #1;
      n_checks++;
      if (evt_valid !== 1'b0 || evt_drop !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flush: evt_valid=%b evt_drop=%b expected 0 0", evt_valid, evt_drop);
      end
      rst = 1'b0;
      evt_ready = 1'b1;
      step(8'h20);
      step(8'h21);
   endtask

   initial begin
      rst = 1'b1; q_in = 8'h00; updown = 1'b1; thresh = 8'h00;
      thresh_we = 1'b0; clr_stats = 1'b0; evt_ready = 1'b1;
      pv_m = 1'b0; prev_m = 8'h00; thr_m = 8'hFF; wc_m = 8'h00; drop_m = 1'b0;
      test_reset();
      test_no_events();
      test_wrap();
      test_thresh();
      test_jump();
      test_overflow();
      test_saturate();
      test_reset_flush();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL leftover_events: pending=%0d expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
